// File: rtl/if_iq_pkg.sv
// if_iq_pkg: shared entry type and sizing for the fetch/decode instruction queue
package if_iq_pkg;
    localparam int PC_BITS     = 32;
    localparam int INSTR_BITS  = 32;
    localparam int IQ_DEPTH    = 8;
    localparam int FETCH_WIDTH = 2;
    localparam int IQ_PTR_W    = $clog2(IQ_DEPTH);

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] instr;
        logic                  pred_taken;
        logic [PC_BITS-1:0]    pred_target;
    } fetch_entry_t;
endpackage

// File: rtl/if_iq_storage.sv
// if_iq_storage: circular entry array with two write ports and two async read ports
module if_iq_storage
    import if_iq_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PW    = IQ_PTR_W
) (
    input  logic                                  clk,
    input  logic         [FETCH_WIDTH-1:0]        we,
    input  logic         [FETCH_WIDTH-1:0][PW-1:0] waddr,
    input  fetch_entry_t [FETCH_WIDTH-1:0]        wdata,
    input  logic         [FETCH_WIDTH-1:0][PW-1:0] raddr,
    output fetch_entry_t [FETCH_WIDTH-1:0]        rdata
);
    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) mem_q[waddr[0]] <= wdata[0];
        if (we[1]) mem_q[waddr[1]] <= wdata[1];
    end

    assign rdata[0] = mem_q[raddr[0]];
    assign rdata[1] = mem_q[raddr[1]];
endmodule

// File: rtl/if_instr_queue.sv
// if_instr_queue: two-wide fetch/decode decoupling queue with flush.
// Define IF_IQ_BYPASS_EN to forward inputs straight to decode when the queue is empty.
module if_instr_queue
    import if_iq_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                in_valid,
    output logic                      in_ready,
    input  logic [2*PC_BITS-1:0]      in_pc,
    input  logic [2*INSTR_BITS-1:0]   in_instr,
    input  logic [1:0]                in_pred_taken,
    input  logic [2*PC_BITS-1:0]      in_pred_target,
    output logic [1:0]                out_valid,
    input  logic [1:0]                out_ready,
    output logic [2*PC_BITS-1:0]      out_pc,
    output logic [2*INSTR_BITS-1:0]   out_instr,
    output logic [1:0]                out_pred_taken,
    output logic [2*PC_BITS-1:0]      out_pred_target,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t [FETCH_WIDTH-1:0]        in_e, q_e, out_e, wdata;
    logic         [FETCH_WIDTH-1:0][PW-1:0] waddr, raddr;
    logic         [FETCH_WIDTH-1:0]        we;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    q_valid, n_in, n_out, n_pop, n_skip, n_wr;
    logic          byp;

    for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
        assign in_e[l] = '{pc:          in_pc[l*PC_BITS +: PC_BITS],
                           instr:       in_instr[l*INSTR_BITS +: INSTR_BITS],
                           pred_taken:  in_pred_taken[l],
                           pred_target: in_pred_target[l*PC_BITS +: PC_BITS]};
        assign out_pc[l*PC_BITS +: PC_BITS]          = out_e[l].pc;
        assign out_instr[l*INSTR_BITS +: INSTR_BITS] = out_e[l].instr;
        assign out_pred_taken[l]                     = out_e[l].pred_taken;
        assign out_pred_target[l*PC_BITS +: PC_BITS] = out_e[l].pred_target;
    end

`ifdef IF_IQ_BYPASS_EN
    assign byp = !rst && !flush && count_q == '0;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = !rst && count_q <= CW'(DEPTH - 2);
    assign q_valid   = rst ? 2'b00 : {count_q >= CW'(2), count_q >= CW'(1)};
    assign out_valid = byp ? (in_valid == 2'b11 ? 2'b11 : in_valid == 2'b01 ? 2'b01 : 2'b00) : q_valid;
    assign out_e     = byp ? in_e : q_e;
    assign occupancy = count_q;

    assign n_in   = !in_ready ? 2'd0 : in_valid == 2'b01 ? 2'd1 : in_valid == 2'b11 ? 2'd2 : 2'd0;
    assign n_out  = {1'b0, out_valid[0] & out_ready[0]} + {1'b0, out_valid[1] & out_ready[1] & out_ready[0]};
    // In bypass, lanes decode took are skipped instead of popped from the (empty) queue
    assign n_pop  = byp ? 2'd0 : n_out;
    assign n_skip = byp ? n_out : 2'd0;
    assign n_wr   = n_in - n_skip;

    assign we       = flush ? 2'b00 : {n_wr == 2'd2, n_wr != 2'd0};
    assign waddr[0] = tail_q;
    assign waddr[1] = tail_q + PW'(1);
    assign wdata[0] = n_skip == 2'd1 ? in_e[1] : in_e[0];
    assign wdata[1] = in_e[1];
    assign raddr[0] = head_q;
    assign raddr[1] = head_q + PW'(1);

    assign head_d  = head_q + PW'(n_pop);
    assign tail_d  = tail_q + PW'(n_wr);
    assign count_d = count_q + CW'(n_wr) - CW'(n_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    if_iq_storage #(.DEPTH(DEPTH), .PW(PW)) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (q_e)
    );

    a_lane1_needs_lane0: assert property (@(posedge clk) disable iff (rst) in_valid != 2'b10);
endmodule

// File: tb/tb_if_instr_queue.sv
// tb_if_instr_queue: directed checks of reset, fill, wrap, partial pop, flush and bypass
module tb_if_instr_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  in_valid = '0, out_ready = '0, in_pred_taken = '0;
    logic [63:0] in_pc = '0, in_instr = '0, in_pred_target = '0;
    logic        in_ready;
    logic [1:0]  out_valid, out_pred_taken;
    logic [63:0] out_pc, out_instr, out_pred_target;
    logic [3:0]  occupancy;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    if_instr_queue dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instr        (in_instr),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_pred_taken  (out_pred_taken),
        .out_pred_target (out_pred_target),
        .occupancy       (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc, input logic [1:0] rdy);
        in_valid       = v;
        out_ready      = rdy;
        in_pc          = {pc + 32'h4, pc};
        in_instr       = {~(pc + 32'h4), ~pc};
        in_pred_taken  = 2'b10;
        in_pred_target = {pc + 32'h104, pc + 32'h100};
        #1;
    endtask

    initial begin
        drive(2'b00, 32'h0, 2'b00);
        tick;
        tick;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 32'(8 * i), 2'b00);
            check("fill_occ", 64'(occupancy), (i < 4) ? 64'(2 * i) : 64'd8);
            check("fill_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            tick;
        end
        check("fill_occ_final", 64'(occupancy), 64'd8);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 32'h0, 2'b11);
            check("drain_valid", 64'(out_valid), 64'd3);
            check("drain_pc", out_pc, {32'(8 * k + 4), 32'(8 * k)});
            check("drain_instr", out_instr, {~32'(8 * k + 4), ~32'(8 * k)});
            check("drain_taken", 64'(out_pred_taken), 64'd2);
            check("drain_target", out_pred_target, {32'(8 * k + 32'h104), 32'(8 * k + 32'h100)});
            tick;
        end
        check("drain_occ", 64'(occupancy), 64'd0);
        check("drain_valid_empty", 64'(out_valid), 64'd0);

        drive(2'b11, 32'h100, 2'b00);
        tick;
        drive(2'b11, 32'h108, 2'b00);
        tick;
        for (int c = 0; c < 20; c++) begin
            drive(2'b11, 32'h110 + 32'(8 * c), 2'b11);
            check("wrap_occ", 64'(occupancy), 64'd4);
            check("wrap_pc", out_pc, {32'h104 + 32'(8 * c), 32'h100 + 32'(8 * c)});
            tick;
        end
        drive(2'b01, 32'h300, 2'b00);
        tick;
        check("pre_flush_occ", 64'(occupancy), 64'd5);

        flush = 1'b1;
        drive(2'b11, 32'h400, 2'b11);
        check("flush_old_valid", 64'(out_valid), 64'd3);
        check("flush_old_pc", 64'(out_pc[31:0]), 64'h1a0);
        tick;
        flush = 1'b0;
        drive(2'b00, 32'h0, 2'b00);
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        tick;
        check("flush_input_lost", 64'(occupancy), 64'd0);

        drive(2'b11, 32'h200, 2'b00);
        tick;
        drive(2'b01, 32'h208, 2'b00);
        tick;
        check("partial_occ3", 64'(occupancy), 64'd3);
        drive(2'b00, 32'h0, 2'b10);
        check("partial_valid", 64'(out_valid), 64'd3);
        tick;
        check("partial_10_occ", 64'(occupancy), 64'd3);
        check("partial_10_pc", 64'(out_pc[31:0]), 64'h200);
        drive(2'b00, 32'h0, 2'b01);
        tick;
        check("partial_01_occ", 64'(occupancy), 64'd2);
        check("partial_01_pc", out_pc, {32'h208, 32'h204});
        drive(2'b00, 32'h0, 2'b11);
        tick;
        check("partial_drain_occ", 64'(occupancy), 64'd0);

        drive(2'b11, 32'h40, 2'b01);
`ifdef IF_IQ_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd3);
        check("byp_pc", 64'(out_pc[31:0]), 64'h40);
        tick;
        drive(2'b00, 32'h0, 2'b00);
        check("byp_occ", 64'(occupancy), 64'd1);
        check("byp_head_pc", 64'(out_pc[31:0]), 64'h44);
        check("byp_next_valid", 64'(out_valid), 64'd1);
`else
        check("nobyp_valid", 64'(out_valid), 64'd0);
        tick;
        drive(2'b00, 32'h0, 2'b00);
        check("nobyp_occ", 64'(occupancy), 64'd2);
        check("nobyp_head_pc", 64'(out_pc[31:0]), 64'h40);
        check("nobyp_next_valid", 64'(out_valid), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
